// File: rtl/cnt_ctrl_pkg.sv
// Shared definitions for the dual counter controller: state encoding and
// the default counter width.
package cnt_ctrl_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FORCED = 2'd2
   } state_t;

endpackage

// File: rtl/cnt_lane.sv
// One counter lane. The controller keeps clear, load and inc mutually
// exclusive; if they overlap anyway, inc wins over load and load wins over
// clear. The wrap pulse is raised only when an increment rolls the count
// from all-ones back to zero.
module cnt_lane
   import cnt_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap
);

   // Count register with registered wrap pulse; everything returns to 0 on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         wrap <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (inc) begin
            cnt  <= cnt + 1'b1;
            wrap <= &cnt;
         end else if (load) begin
            cnt <= load_val;
         end else if (clear) begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/dual_cnt_ctrl.sv
// Sequencing controller for two counters x/y with a synthesizable
// force/release override. The FSM decides, each cycle, whether the lanes
// clear, load the override values, increment or hold.
module dual_cnt_ctrl
   import cnt_ctrl_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit Y_CASCADE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             force_req,
   input  logic [WIDTH-1:0] force_x,
   input  logic [WIDTH-1:0] force_y,
   input  logic             rel_req,
   output logic             force_ack,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             wrap_x,
   output logic             wrap_y,
   output logic [1:0]       state
);

   state_t cur, nxt;
   logic   clr, ld, inc_x, inc_y, ack_d;

   // State register; reset aborts any override immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur <= IDLE;
      else     cur <= nxt;
   end

   // Next state: a force strobe always enters FORCED, except that inside
   // FORCED a release strobe takes precedence over it.
   always_comb begin
      nxt = cur;
      case (cur)
         IDLE: begin
            if (force_req) nxt = FORCED;
            else if (en)   nxt = RUN;
         end
         RUN: begin
            if (force_req) nxt = FORCED;
            else if (!en)  nxt = IDLE;
         end
         FORCED: begin
            if (rel_req) nxt = en ? RUN : IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Lane controls. IDLE clears every edge, including the edge that enters
   // RUN, so the first increment lands one cycle after enable rises. The
   // release edge neither loads nor increments, so values hold across it.
   always_comb begin
      clr   = 1'b0;
      ld    = 1'b0;
      inc_x = 1'b0;
      case (cur)
         IDLE: begin
            ld  = force_req;
            clr = !force_req;
         end
         RUN: begin
            ld    = force_req;
            clr   = !force_req && !en;
            inc_x = !force_req && en;
         end
         FORCED: begin
            ld = force_req && !rel_req;
         end
         default: clr = 1'b1;
      endcase
      inc_y = inc_x && (!Y_CASCADE || (&x));
      ack_d = ld;
   end

   // Acknowledge is high in the cycle the override values become visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) force_ack <= 1'b0;
      else     force_ack <= ack_d;
   end

   cnt_lane #(.WIDTH(WIDTH)) u_lane_x (
      .clk      (clk),
      .rst      (rst),
      .clear    (clr),
      .load     (ld),
      .load_val (force_x),
      .inc      (inc_x),
      .cnt      (x),
      .wrap     (wrap_x)
   );

   cnt_lane #(.WIDTH(WIDTH)) u_lane_y (
      .clk      (clk),
      .rst      (rst),
      .clear    (clr),
      .load     (ld),
      .load_val (force_y),
      .inc      (inc_y),
      .cnt      (y),
      .wrap     (wrap_y)
   );

   assign state = cur;

endmodule

// File: tb/tb_dual_cnt_ctrl.sv
// Randomized and directed bench for dual_cnt_ctrl. Two instances share the
// stimulus: one with independent y, one with y cascaded from x. The model
// treats the cascaded pair as a single 8-bit counter.
module tb_dual_cnt_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, force_req = 1'b0, rel_req = 1'b0;
   logic [3:0] force_x = '0, force_y = '0;

   logic       ack0, wx0, wy0, ack1, wx1, wy1;
   logic [3:0] x0, y0, x1, y1;
   logic [1:0] st0, st1;

   int errs = 0;
   int checks = 0;

   // model state
   int m_st = 0, m_x = 0, m_y0 = 0, m_v1 = 0;
   int e_ack = 0, e_wx = 0, e_wy0 = 0, e_wy1 = 0;

   always #5 clk = ~clk;

   dual_cnt_ctrl #(.WIDTH(4), .Y_CASCADE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .force_req(force_req),
      .force_x(force_x), .force_y(force_y), .rel_req(rel_req),
      .force_ack(ack0), .x(x0), .y(y0), .wrap_x(wx0), .wrap_y(wy0),
      .state(st0));

   dual_cnt_ctrl #(.WIDTH(4), .Y_CASCADE(1'b1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .force_req(force_req),
      .force_x(force_x), .force_y(force_y), .rel_req(rel_req),
      .force_ack(ack1), .x(x1), .y(y1), .wrap_x(wx1), .wrap_y(wy1),
      .state(st1));

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_x = 0; m_y0 = 0; m_v1 = 0;
      e_ack = 0; e_wx = 0; e_wy0 = 0; e_wy1 = 0;
   endtask

   // One clock of reference behaviour given the inputs sampled at the edge.
   task automatic model_edge(input int e, input int fr, input int rr,
                             input int fx, input int fy);
      bit do_load, do_clr, do_inc;
      do_load = 0; do_clr = 0; do_inc = 0;
      e_ack = 0; e_wx = 0; e_wy0 = 0; e_wy1 = 0;
      if (m_st == 2) begin
         if (rr)      m_st = e ? 1 : 0;
         else if (fr) do_load = 1;
      end else if (fr) begin
         do_load = 1;
      end else if (m_st == 0) begin
         do_clr = 1;
         if (e) m_st = 1;
      end else begin
         if (e) do_inc = 1;
         else begin do_clr = 1; m_st = 0; end
      end
      if (do_load) begin
         m_st = 2; m_x = fx; m_y0 = fy; m_v1 = fy * 16 + fx; e_ack = 1;
      end
      if (do_clr) begin
         m_x = 0; m_y0 = 0; m_v1 = 0;
      end
      if (do_inc) begin
         e_wx  = (m_x == 15);
         e_wy0 = (m_y0 == 15);
         e_wy1 = (m_v1 == 255);
         m_x  = (m_x + 1) % 16;
         m_y0 = (m_y0 + 1) % 16;
         m_v1 = (m_v1 + 1) % 256;
      end
   endtask

   task automatic check_all();
      chk("x0", int'(x0), m_x);
      chk("y0", int'(y0), m_y0);
      chk("ack0", int'(ack0), e_ack);
      chk("wrap_x0", int'(wx0), e_wx);
      chk("wrap_y0", int'(wy0), e_wy0);
      chk("state0", int'(st0), m_st);
      chk("x1", int'(x1), m_v1 % 16);
      chk("y1", int'(y1), m_v1 / 16);
      chk("ack1", int'(ack1), e_ack);
      chk("wrap_x1", int'(wx1), e_wx);
      chk("wrap_y1", int'(wy1), e_wy1);
      chk("state1", int'(st1), m_st);
   endtask

   task automatic step(input int e, input int fr, input int rr,
                       input int fx, input int fy);
      @(negedge clk);
      en = e[0]; force_req = fr[0]; rel_req = rr[0];
      force_x = fx[3:0]; force_y = fy[3:0];
      @(posedge clk);
      #1;
      model_edge(e, fr, rr, fx, fy);
      check_all();
   endtask

   initial begin
      int guard;
      // reset state
      #23;
      model_reset();
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // enable for 20 cycles: 0 first, then 1..15, 0 with wraps, 1..
      for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);

      // drop and re-raise enable, run to x=5, then force 9/3
      step(0, 0, 0, 0, 0);
      guard = 0;
      while (m_x != 5 && guard < 40) begin
         step(1, 0, 0, 0, 0);
         guard++;
      end
      chk("reach_x5", m_x, 5);
      step(1, 1, 0, 9, 3);
      chk("forced_x", int'(x0), 9);
      chk("forced_ack", int'(ack0), 1);
      for (int i = 0; i < 10; i++) step(i % 2, 0, 0, i, i);
      step(1, 0, 1, 0, 0);
      chk("rel_hold_x", int'(x0), 9);
      step(1, 0, 0, 0, 0);
      chk("after_rel_x", int'(x0), 10);
      chk("after_rel_y", int'(y0), 4);

      // force then simultaneous force+release: release wins
      step(1, 1, 0, 2, 6);
      step(1, 1, 1, 7, 7);
      chk("simul_x", int'(x0), 2);
      chk("simul_state", int'(st0), 1);

      // drop enable in RUN
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // long run for cascade behaviour
      for (int i = 0; i < 40; i++) step(1, 0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 9) != 0) ? 1 : 0,
              ($urandom_range(0, 11) == 0) ? 1 : 0,
              ($urandom_range(0, 3) == 0) ? 1 : 0,
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

      // async reset while FORCED
      step(1, 1, 0, 12, 13);
      @(negedge clk);
      force_req = 1'b0;
      @(posedge clk);
      model_edge(1, 0, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #1;
      rst = 1'b0;
      step(1, 0, 0, 0, 0);
      chk("post_rst_state", int'(st0), 1);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/dual_cnt_ctrl.md
# dual_cnt_ctrl

Sequencing controller for a pair of 4-bit counters `x`/`y`. It clears them while disabled and increments them while enabled. It also supports a force/release override: forced values are loaded and held, and counting resumes from them once released. The block sits between the enable/override control logic and any consumer of the two count values. It replaces procedural force/release constructs with a synthesizable registered state machine.

## Interface
- `WIDTH`, 4, counter width for `x`, `y`, `force_x`, `force_y`
- `Y_CASCADE`, 0, 0: `y` increments with `x` every RUN cycle; 1: `y` increments only on `x` wrap
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  count enable (level)
- `force_req`  in  1  single-cycle strobe: load `force_x`/`force_y` and hold
- `force_x`  in  WIDTH  override value for `x`, sampled with `force_req`
- `force_y`  in  WIDTH  override value for `y`, sampled with `force_req`
- `rel_req`  in  1  single-cycle strobe: release override
- `force_ack`  out  1  one-cycle pulse, override values applied
- `x`  out  WIDTH  counter x (registered)
- `y`  out  WIDTH  counter y (registered)
- `wrap_x`  out  1  one-cycle pulse, `x` wrapped max→0 by increment
- `wrap_y`  out  1  one-cycle pulse, `y` wrapped max→0 by increment
- `state`  out  2  0=IDLE, 1=RUN, 2=FORCED

## Operation
- Reset values: `x`=0, `y`=0, `force_ack`=0, `wrap_x`=0, `wrap_y`=0, `state`=IDLE. Reset mid-operation aborts any override immediately.
- IDLE:
  - `x`,`y` ← 0 every edge.
  - `force_req` → FORCED (load, ack).
  - Else `en`=1 → RUN, with counts remaining 0 on that edge.
- RUN:
  - `force_req` → FORCED (load, ack).
  - Else `en`=0 → IDLE with `x`,`y` ← 0.
  - Else `x` ← `x`+1.
  - `y` ← `y`+1 when `Y_CASCADE`=0, or when `x`=max if `Y_CASCADE`=1.
- FORCED:
  - `en` is ignored.
  - `rel_req` → RUN if `en`=1, else IDLE. Counts are unchanged on the release edge.
  - Else `force_req` → reload new values and pulse `force_ack`; stay FORCED.
  - Else hold.
- Simultaneous `rel_req` and `force_req` in FORCED: release wins and `force_req` is dropped, with no ack.
- `rel_req` outside FORCED is ignored.
- Arithmetic is modulo 2^WIDTH. Wrap pulses fire only on an increment from max to 0, never on clear, force or reset.

## Timing
- All outputs are registered, with no combinational input→output paths.
- `force_req` at edge n:
  - `x`/`y` = forced values after edge n.
  - `force_ack`=1 for exactly that cycle.
  - `state`=FORCED.
- `rel_req` at edge m:
  - State changes after m, with values held.
  - First increment after edge m+1 (RUN case), or clear after edge m+1 (IDLE case).
- `en` rising in IDLE at edge k: first increment after edge k+1.
- `en` falling in RUN at edge k: `x`=`y`=0 after edge k.
- `wrap_x`/`wrap_y` are high in the same cycle that the wrapped value 0 is visible on `x`/`y`.

## Structure
- Shared package `cnt_ctrl_pkg`:
  - state encoding `IDLE`/`RUN`/`FORCED` (2-bit typedef)
  - default `WIDTH` constant
- Sub-module `cnt_lane`, instantiated twice (x, y):
  - inputs: clear, load, load value, inc
  - outputs: count register, wrap pulse
  - priority: clear < load < inc
- The top level holds only the FSM, the `force_ack` register and the `Y_CASCADE` increment select.

## Test plan
- Reset, then `en`=1 for 20 cycles (`Y_CASCADE`=0):
  - `x`=`y`=0 one cycle after `en` rises, then 1,2,…,15,0,1,…
  - `wrap_x`=`wrap_y`=1 in the cycle both read 0 after 15.
- `Y_CASCADE`=1, `en`=1 for 40 cycles:
  - `y` increments only when `x` goes 15→0.
  - `y`=2 after 32 increments.
  - `wrap_y` is never asserted.
- In RUN at `x`=5, `force_req` with `force_x`=9, `force_y`=3:
  - next cycle `x`=9, `y`=3, `force_ack`=1, `state`=2.
  - Holds 9/3 for 10 cycles while `en` toggles.
  - `rel_req` with `en`=1 → values 9/3 for one more cycle, then 10/4.
- In FORCED, `force_req` and `rel_req` in the same cycle with `force_x`=7:
  - release taken; `x` keeps the old value; no `force_ack`; `state`=RUN.
- In RUN, drop `en` → `x`=`y`=0 next cycle, `state`=IDLE, no wrap pulse.
- Assert `rst` asynchronously mid-FORCED (between edges):
  - outputs go to 0/IDLE immediately, without waiting for a clock edge.
  - After deassertion with `en`=1: RUN after one edge, then counting from 0.
